t_counter_using_d: RTL
======================

# t_counter_using_d

- N-bit synchronous toggle register built on D-type storage.
- Each bit's next state is `q ^ t`, the inverse of the D-from-T conversion.
- Two modes:
  - **Toggle mode:** the toggle vector comes from the `t` port.
  - **Count mode:** the toggle vector comes from an internal carry chain, which forms a classic synchronous up/down counter of T cells.
- Sits with the flip-flop conversion blocks and serves as the reusable multi-bit T-register/counter primitive for later counter and divider designs.

## Interface
- `W`, default 4: register width, ≥ 2.
- `clk` input, 1 bit: clock; every state change happens on its rising edge.
- `cr` input, 1 bit: clear. Synchronous, active-high; sets `q` to all zeros.
- `pr` input, 1 bit: preset. Synchronous, active-high; sets `q` to all ones.
- `en` input, 1 bit: toggle/count enable.
- `mode` input, 1 bit: 0 = external toggle, 1 = count.
- `up` input, 1 bit: count direction, 1 = up, 0 = down. Used only when `mode`=1.
- `t` input, W bits: per-bit toggle request. Used only when `mode`=0.
- `load` input, 1 bit: synchronous parallel load.
- `d` input, W bits: load value.
- `q` output, W bits: register state.
- `q_bar` output, W bits: always `~q`.
- `tc` output, 1 bit: terminal count, combinational.
- `wrap` output, 1 bit: registered one-cycle wrap pulse.

## Operation
- Storage:
  - W D flip-flops plus one `wrap` flop.
  - The D input of bit i is the selected next value. No storage element other than D flops.
- Priority per rising edge, highest first:
  - `cr`: `q`=0, `wrap`=0.
  - `pr`: `q`=all ones, `wrap`=0.
  - `load`: `q`=`d`, `wrap`=0.
  - `en`: toggle or count (below).
  - Otherwise: hold, `wrap`=0.
- `cr` and `pr` both high: clear wins, `q`=0.
- Toggle mode (`mode`=0, `en`=1):
  - `q` ← `q ^ t`.
  - `t` = 0 → hold.
  - `wrap` ← 0.
- Count mode (`mode`=1, `en`=1), toggle vector for bit i:
  - up: 1 iff bits 0..i-1 are all 1.
  - down: 1 iff bits 0..i-1 are all 0.
  - Bit 0 always toggles.
  - `q` ← `q ^ toggle`, modulo 2^W.
  - `t` is ignored.
- `tc` = `mode` & `en` & (`up` ? (`q` == all ones) : (`q` == 0)).
- `wrap` ← `tc` whenever a count step occurs.
  - Goes high in the cycle after `q` wraps: all ones → 0 counting up, 0 → all ones counting down.
  - 0 otherwise.
- `en`=0: `q` holds and `tc`=0, except during `cr`/`pr`/`load`.
- `up` or `mode` changing mid-sequence takes effect on the next edge. No internal state besides `q` and `wrap`.

## Timing
- Reset (`cr`) values:
  - `q`=0
  - `q_bar`=all ones
  - `wrap`=0
  - `tc`=`mode`&`en`&~`up`, so 1 if counting down and enabled.
- Latency:
  - `q`, `q_bar`, `wrap`: one cycle from the sampling edge.
  - `tc`: zero-cycle combinational from `q`, `mode`, `en`, `up`.
- `q_bar` updates on the same edge as `q`, never as a separate flop out of phase.
- `cr` asserted mid-count: `q`=0 at the next edge and any pending wrap pulse is suppressed. Counting resumes from 0 on the first edge with `cr`=0.
- `load` at terminal count while counting: the load value wins and `wrap`=0.
- Full count period: 2^W enabled edges. `wrap` is high exactly once per period.

## Test plan (W=4)
1. **Clear:**
   - Stimulus: `cr`=1 for one edge from random `q`.
   - Required: `q`=0000, `q_bar`=1111, `wrap`=0. With `mode`=1, `en`=1, `up`=0: `tc`=1.
2. **Toggle mode:**
   - Stimulus: `q`=0101, `mode`=0, `en`=1, `t`=0011.
   - Required: after one edge `q`=0110. `t`=0000 for 3 edges → `q` stays 0110.
3. **Count up with wrap:**
   - Stimulus: from 0000, `mode`=1, `up`=1, `en`=1 for 17 edges.
   - Required: `q` steps 0001..1111, 0000, 0001. `tc`=1 only while `q`=1111. `wrap`=1 only in the cycle `q`=0000 after 1111.
4. **Count down:**
   - Stimulus: `load` `d`=0010, then count down for 4 edges.
   - Required: `q` = 0001, 0000, 1111, 1110. `wrap` pulses once, when `q` becomes 1111.
5. **Priority:**
   - Stimulus: `cr`=`pr`=`load`=1, `d`=1010.
   - Required: `q`=0000.
   - Stimulus: `pr`=`load`=1.
   - Required: `q`=1111.
   - Stimulus: `load`=1 with `en`=1, `tc`=1.
   - Required: `q`=`d`, `wrap`=0.
6. **Hold:**
   - Stimulus: `en`=0, `mode`=1, `q`=1111, `up`=1 for 5 edges.
   - Required: `q`=1111, `tc`=0, `wrap`=0 throughout.

Source files
------------

// File: rtl/t_counter_using_d.sv
// Multi-bit T register / synchronous up-down counter built only from D flops.
// Each bit stores q ^ toggle; the toggle vector comes from the t port or a carry chain.

module t_counter_tcell (
  input  logic clk_i,
  input  logic cr_i,
  input  logic pr_i,
  input  logic load_i,
  input  logic d_i,
  input  logic tgl_i,
  output logic q_o
);
  logic q_q, q_d;

  always_comb begin
    q_d = q_q ^ tgl_i;
    if (cr_i)        q_d = 1'b0;
    else if (pr_i)   q_d = 1'b1;
    else if (load_i) q_d = d_i;
  end

  always_ff @(posedge clk_i) q_q <= q_d;

  assign q_o = q_q;
endmodule

module t_counter_using_d #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         cr_i,
  input  logic         pr_i,
  input  logic         en_i,
  input  logic         mode_i,
  input  logic         up_i,
  input  logic [W-1:0] t_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] q_bar_o,
  output logic         tc_o,
  output logic         wrap_o
);
  logic [W-1:0] q, carry, tgl;
  logic         wrap_q, wrap_d;

  // carry[i]: all lower bits are 1 (up) or all 0 (down)
  assign carry[0] = 1'b1;
  for (genvar i = 1; i < W; i++) begin : g_carry
    assign carry[i] = carry[i-1] & (up_i ? q[i-1] : ~q[i-1]);
  end

  assign tgl = !en_i ? '0 : (mode_i ? carry : t_i);

  for (genvar i = 0; i < W; i++) begin : g_cell
    t_counter_tcell u_cell (
      .clk_i  (clk_i),
      .cr_i   (cr_i),
      .pr_i   (pr_i),
      .load_i (load_i),
      .d_i    (d_i[i]),
      .tgl_i  (tgl[i]),
      .q_o    (q[i])
    );
  end

  assign tc_o = mode_i & en_i & (up_i ? (&q) : ~(|q));

  // tc already implies a count step; any clear/preset/load overrides it
  assign wrap_d = tc_o & ~cr_i & ~pr_i & ~load_i;

  always_ff @(posedge clk_i) begin
    if (cr_i) wrap_q <= 1'b0;
    else      wrap_q <= wrap_d;
  end

  assign q_o     = q;
  assign q_bar_o = ~q;
  assign wrap_o  = wrap_q;
endmodule
